// File: rtl/mandelbrot_iter_ctrl.sv
// mandelbrot_iter_ctrl
//   Job sequencer around an external combinational Mandelbrot step unit
//   (z' = z^2 + c). Takes one point c per job and loops z through the step unit
//   once per clock until z escapes or MAX_ITER steps have run. It then returns
//   the iteration count and an escaped flag.
//   Optional feature macro: MANDEL_CIRCLE_TEST_EN
//     - defined:   the escape test is zr^2 + zi^2 >= 4.0.
//     - undefined: the escape test is the box |zr| >= 2.0 or |zi| >= 2.0,
//                  and this block contains no multipliers.
module mandelbrot_iter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int FRAC     = 5,
  parameter int MAX_ITER = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_cr,
  input  logic [WIDTH-1:0] in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] iter_count,
  output logic             escaped,
  output logic [WIDTH-1:0] dp_cr,
  output logic [WIDTH-1:0] dp_ci,
  output logic [WIDTH-1:0] dp_zr,
  output logic [WIDTH-1:0] dp_zi,
  input  logic [WIDTH-1:0] dp_nzr,
  input  logic [WIDTH-1:0] dp_nzi
);

  // Elaboration-time checks. The counter must never wrap, and +/-2.0 must be representable.
  if (MAX_ITER < 1 || MAX_ITER > (1 << CNT_W) - 1) begin : g_chk_iter
    $error("mandelbrot_iter_ctrl: MAX_ITER must be in 1..2^CNT_W-1");
  end
  if (FRAC > WIDTH - 3) begin : g_chk_frac
    $error("mandelbrot_iter_ctrl: FRAC must be <= WIDTH-3");
  end

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                   state, state_nxt;
  logic signed [WIDTH-1:0]  cr, ci, zr, zi;
  logic signed [WIDTH-1:0]  nz_r, nz_i;
  logic [CNT_W-1:0]         cnt, cnt_inc;
  logic                     esc_q, out_vld_q;
  logic                     esc_hit, last_iter, hs;
  logic                     ld, step;

  assign nz_r      = $signed(dp_nzr);
  assign nz_i      = $signed(dp_nzi);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_iter = (cnt_inc == CNT_W'(MAX_ITER));
  assign hs        = out_vld_q & out_ready;

`ifdef MANDEL_CIRCLE_TEST_EN
  // Circle test: the products keep full precision, so the magnitude cannot overflow.
  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [PW-1:0] FOUR = PW'(4 << (2 * FRAC));
  logic signed [2*WIDTH-1:0] sq_r, sq_i;
  logic signed [PW-1:0]      mag;
  assign sq_r    = (2 * WIDTH)'(nz_r) * (2 * WIDTH)'(nz_r);
  assign sq_i    = (2 * WIDTH)'(nz_i) * (2 * WIDTH)'(nz_i);
  assign mag     = PW'(sq_r) + PW'(sq_i);
  assign esc_hit = (mag >= FOUR);
`else
  // Box test: a signed compare against +/-2.0 on each component.
  localparam logic signed [WIDTH-1:0] TWO  = WIDTH'(2 << FRAC);
  localparam logic signed [WIDTH-1:0] NTWO = -TWO;
  assign esc_hit = (nz_r >= TWO) || (nz_r <= NTWO) ||
                   (nz_i >= TWO) || (nz_i <= NTWO);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Abort overrides every other event.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    step      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ld        = 1'b1;
          state_nxt = ITER;
        end
        ITER: begin
          step = 1'b1;
          if (esc_hit || last_iter) state_nxt = DONE;
        end
        DONE: if (hs) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath registers: c, z, the counter and the result flags.
  // out_valid is registered from DONE. This adds the one cycle between the
  // terminal iteration and result presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr        <= '0;
      ci        <= '0;
      zr        <= '0;
      zi        <= '0;
      cnt       <= '0;
      esc_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (abort) begin
      zr        <= '0;
      zi        <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (ld) begin
        cr  <= $signed(in_cr);
        ci  <= $signed(in_ci);
        zr  <= '0;
        zi  <= '0;
        cnt <= '0;
      end
      if (step) begin
        zr  <= nz_r;
        zi  <= nz_i;
        cnt <= cnt_inc;
        // Escape wins over the iteration limit when both hold in the same cycle.
        if (esc_hit || last_iter) esc_q <= esc_hit;
      end
      out_vld_q <= (state == DONE) && !hs;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = out_vld_q;
  assign iter_count = cnt;
  assign escaped    = esc_q;
  assign dp_cr      = cr;
  assign dp_ci      = ci;
  assign dp_zr      = zr;
  assign dp_zi      = zi;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// tb_mandelbrot_iter_ctrl
//   Bench for mandelbrot_iter_ctrl (WIDTH=8, FRAC=5, MAX_ITER=15; 1.0 = 32).
//   Behavioural model of the external step unit (z^2 + c, wrapping) is driven
//   back into the DUT. Expected results are queued per job and popped on out_valid.
//   Honours MANDEL_CIRCLE_TEST_EN when the design is built with it.
module tb_mandelbrot_iter_ctrl;
  localparam int WIDTH    = 8;
  localparam int FRAC     = 5;
  localparam int MAX_ITER = 15;
  localparam int CNT_W    = 4;

  logic             clk, rst_n, abort;
  logic             in_valid, in_ready, out_valid, out_ready, escaped;
  logic [WIDTH-1:0] in_cr, in_ci;
  logic [CNT_W-1:0] iter_count;
  logic [WIDTH-1:0] dp_cr, dp_ci, dp_zr, dp_zi, dp_nzr, dp_nzi;

  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];   // {escaped, iter_count}

  mandelbrot_iter_ctrl #(.WIDTH(WIDTH), .FRAC(FRAC), .MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_cr(in_cr), .in_ci(in_ci),
    .out_valid(out_valid), .out_ready(out_ready),
    .iter_count(iter_count), .escaped(escaped),
    .dp_cr(dp_cr), .dp_ci(dp_ci), .dp_zr(dp_zr), .dp_zi(dp_zi),
    .dp_nzr(dp_nzr), .dp_nzi(dp_nzi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step unit model: Q(FRAC) fixed point, products shifted back, result wraps to 8 bits.
  function automatic logic [7:0] step_r(input logic [7:0] zr, input logic [7:0] zi, input logic [7:0] cr);
    int r, i;
    r = int'($signed(zr));
    i = int'($signed(zi));
    return 8'(((r * r - i * i) >>> FRAC) + int'($signed(cr)));
  endfunction

  function automatic logic [7:0] step_i(input logic [7:0] zr, input logic [7:0] zi, input logic [7:0] ci);
    int r, i;
    r = int'($signed(zr));
    i = int'($signed(zi));
    return 8'(((2 * r * i) >>> FRAC) + int'($signed(ci)));
  endfunction

  assign dp_nzr = step_r(dp_zr, dp_zi, dp_cr);
  assign dp_nzi = step_i(dp_zr, dp_zi, dp_ci);

  function automatic bit esc_fn(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
`ifdef MANDEL_CIRCLE_TEST_EN
    return (x * x + y * y) >= 4096;
`else
    return (x >= 64) || (x <= -64) || (y >= 64) || (y <= -64);
`endif
  endfunction

  // Reference iteration used for the randomly chosen points.
  function automatic logic [4:0] ref_run(input logic [7:0] cr, input logic [7:0] ci);
    logic [7:0] zr, zi, nr, ni;
    zr = 8'h00;
    zi = 8'h00;
    for (int n = 1; n <= MAX_ITER; n++) begin
      nr = step_r(zr, zi, cr);
      ni = step_i(zr, zi, ci);
      zr = nr;
      zi = ni;
      if (esc_fn(zr, zi)) return {1'b1, 4'(n)};
    end
    return {1'b0, 4'(MAX_ITER)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One job: queue the expectation, accept, wait (bounded) for out_valid, then pop and check.
  task automatic do_job(input logic [7:0] cr, input logic [7:0] ci, input logic [4:0] exp, input bit stall);
    logic [4:0] e;
    int cyc;
    exp_q.push_back(exp);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    out_ready = !stall;
    in_valid  = 1'b1;
    in_cr     = cr;
    in_ci     = ci;
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", 32'(in_ready), 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    chk("out_valid_seen", 32'(out_valid), 1);
    chk("iter_count", 32'(iter_count), 32'(e[3:0]));
    chk("escaped", 32'(escaped), 32'(e[4]));
    chk("latency", 32'(cyc), 32'(e[3:0]) + 1);
    if (stall) begin
      for (int k = 0; k < 10; k++) begin
        in_valid = k[0];
        in_cr    = 8'h11;
        @(negedge clk);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_iter_count", 32'(iter_count), 32'(e[3:0]));
        chk("stall_escaped", 32'(escaped), 32'(e[4]));
        chk("stall_in_ready", 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_dropped", 32'(out_valid), 0);
    chk("in_ready_after", 32'(in_ready), 1);
  endtask

  initial begin
    int seen;
    logic [7:0] rr, ri;
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_cr = '0; in_ci = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_iter_count", 32'(iter_count), 0);
    chk("rst_escaped", 32'(escaped), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_dp", 32'({dp_cr, dp_ci, dp_zr, dp_zi}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: c=0 never escapes; test 2: c=1.0 escapes at z2=2.0.
    do_job(8'h00, 8'h00, {1'b0, 4'd15}, 1'b0);
    do_job(8'h20, 8'h00, {1'b1, 4'd2}, 1'b0);
    // Test 3.
`ifdef MANDEL_CIRCLE_TEST_EN
    do_job(8'h30, 8'h30, {1'b1, 4'd1}, 1'b0);
`else
    do_job(8'h30, 8'h00, {1'b1, 4'd2}, 1'b0);
`endif
    // Escape threshold boundaries: -2.0 hits at once, -63 orbits, +63 wraps past -2.0.
    do_job(8'hC0, 8'h00, {1'b1, 4'd1}, 1'b0);
    do_job(8'hC1, 8'h00, {1'b0, 4'd15}, 1'b0);
    do_job(8'h3F, 8'h00, {1'b1, 4'd2}, 1'b0);
    // Test 4: periodic orbit with a 10-cycle consumer stall.
    do_job(8'h00, 8'h20, {1'b0, 4'd15}, 1'b1);

    // Test 5: abort in the 3rd ITER cycle.
    @(negedge clk); in_valid = 1'b1; in_cr = 8'h00; in_ci = 8'h00;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_z", 32'({dp_zr, dp_zi}), 0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen++; end
    chk("abort_no_result", 32'(seen), 0);
    do_job(8'h20, 8'h00, {1'b1, 4'd2}, 1'b0);

    // Test 6: reset in the middle of a job.
    @(negedge clk); in_valid = 1'b1; in_cr = 8'h00; in_ci = 8'h20;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_iter_count", 32'(iter_count), 0);
    chk("midrst_dp", 32'({dp_cr, dp_ci, dp_zr, dp_zi}), 0);
    @(negedge clk); rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen++; end
    chk("midrst_no_result", 32'(seen), 0);
    do_job(8'h20, 8'h00, {1'b1, 4'd2}, 1'b0);

    // A few random points against the reference iteration.
    repeat (6) begin
      rr = 8'($urandom_range(0, 255));
      ri = 8'($urandom_range(0, 255));
      do_job(rr, ri, ref_run(rr, ri), 1'b0);
    end

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
